// File: rtl/count_sweep_controller_if.sv
// Control/status bundle between the sweep sequencer, its host and the
// 4-bit-step up/down counter it steers.
interface count_sweep_controller_if #(
  parameter int COUNT_W = 8,
  parameter int STEP_W  = 4
);
  // Host command and configuration
  logic               i_Start;
  logic               i_Stop;
  logic [STEP_W-1:0]  i_Step;
  logic [COUNT_W-1:0] i_UpperLimit;
  logic [COUNT_W-1:0] i_LowerLimit;
  logic [3:0]         i_Sweeps;
  // Read-back from the counter
  logic [COUNT_W-1:0] i_Count;
  logic               i_AtMidpoint;
  // Counter controls
  logic               o_InializeCount;
  logic               o_EnableCount;
  logic               o_CountUp;
  logic [STEP_W-1:0]  o_N;
  // Status
  logic               o_Busy;
  logic               o_Done;
  logic               o_Error;
  logic [7:0]         o_MidpointCrossings;

  // Host/environment side
  modport master (
    output i_Start, i_Stop, i_Step, i_UpperLimit, i_LowerLimit, i_Sweeps,
           i_Count, i_AtMidpoint,
    input  o_InializeCount, o_EnableCount, o_CountUp, o_N,
           o_Busy, o_Done, o_Error, o_MidpointCrossings
  );

  // Sequencer side
  modport slave (
    input  i_Start, i_Stop, i_Step, i_UpperLimit, i_LowerLimit, i_Sweeps,
           i_Count, i_AtMidpoint,
    output o_InializeCount, o_EnableCount, o_CountUp, o_N,
           o_Busy, o_Done, o_Error, o_MidpointCrossings
  );
endinterface

// File: rtl/count_sweep_controller.sv
// Closed-loop sweep sequencer: loads the counter to its midpoint, then
// ping-pongs it between programmed limits for a programmed number of sweeps,
// tallying rising edges of the counter's midpoint flag.
module count_sweep_controller #(
  parameter int COUNT_W  = 8,
  parameter int STEP_W   = 4,
  parameter int MIDPOINT = 127
) (
  input  logic                     i_Clock,
  input  logic                     i_ResetN,
  count_sweep_controller_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_INIT,
    S_UP,
    S_DOWN,
    S_DONE
  } state_t;

  localparam logic [COUNT_W-1:0] MID_C = COUNT_W'(MIDPOINT);

  state_t             r_state;
  state_t             w_next;
  logic [STEP_W-1:0]  r_step;
  logic [COUNT_W-1:0] r_upper;
  logic [COUNT_W-1:0] r_lower;
  logic [3:0]         r_sweeps;
  logic [3:0]         r_sweep_cnt;
  logic [3:0]         w_sweep_inc;
  logic               r_error;
  logic               r_mid_prev;
  logic [7:0]         r_xings;

  logic               w_cfg_ok;
  logic               w_accept;
  logic               w_active;
  logic               w_drive;
  logic               w_rise;
  logic               w_up_fits;
  logic               w_down_fits;
  logic               w_init;
  logic               w_en;
  logic               w_up;
  logic               w_sweep_bump;
  logic [COUNT_W:0]   w_step_ext;
  logic [COUNT_W:0]   w_count_ext;
  logic [COUNT_W:0]   w_up_sum;
  logic [COUNT_W:0]   w_down_floor;

  // One extra bit on every compare so count+step and lower+step never wrap.
  assign w_step_ext   = {{(COUNT_W+1-STEP_W){1'b0}}, r_step};
  assign w_count_ext  = {1'b0, bus.i_Count};
  assign w_up_sum     = w_count_ext + w_step_ext;
  assign w_down_floor = {1'b0, r_lower} + w_step_ext;
  assign w_up_fits    = (w_up_sum <= {1'b0, r_upper});
  assign w_down_fits  = (w_count_ext >= w_down_floor);

  assign w_cfg_ok    = (bus.i_Step != '0) &&
                       (bus.i_LowerLimit <= MID_C) && (MID_C <= bus.i_UpperLimit);
  assign w_accept    = (r_state == S_IDLE) && bus.i_Start;
  assign w_active    = (r_state == S_INIT) || (r_state == S_UP) || (r_state == S_DOWN);
  assign w_drive     = w_active && !bus.i_Stop;
  assign w_rise      = bus.i_AtMidpoint && !r_mid_prev;
  assign w_sweep_inc = r_sweep_cnt + 4'd1;

  // Next-state and counter-control decode; Stop overrides everything while active
  always_comb begin
    w_next       = r_state;
    w_init       = 1'b0;
    w_en         = 1'b0;
    w_up         = 1'b0;
    w_sweep_bump = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.i_Start && w_cfg_ok) w_next = S_INIT;
      end
      S_INIT: begin
        w_init = 1'b1;
        w_en   = 1'b1;
        w_next = S_UP;
      end
      S_UP: begin
        if (w_up_fits) begin
          w_en = 1'b1;
          w_up = 1'b1;
        end else begin
          w_next = S_DOWN;
        end
      end
      S_DOWN: begin
        if (w_down_fits) begin
          w_en = 1'b1;
        end else begin
          w_sweep_bump = 1'b1;
          w_next = ((r_sweeps != 4'd0) && (w_sweep_inc == r_sweeps)) ? S_DONE : S_UP;
        end
      end
      S_DONE: begin
        w_next = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
    if (w_active && bus.i_Stop) begin
      w_next       = S_IDLE;
      w_init       = 1'b0;
      w_en         = 1'b0;
      w_up         = 1'b0;
      w_sweep_bump = 1'b0;
    end
  end

  // State register
  always_ff @(posedge i_Clock or negedge i_ResetN) begin
    if (!i_ResetN) r_state <= S_IDLE;
    else           r_state <= w_next;
  end

  // Latch the sweep configuration whenever a Start is taken in IDLE
  always_ff @(posedge i_Clock) begin
    if (w_accept) begin
      r_step   <= bus.i_Step;
      r_upper  <= bus.i_UpperLimit;
      r_lower  <= bus.i_LowerLimit;
      r_sweeps <= bus.i_Sweeps;
    end
  end

  // Completed-sweep counter, restarted on a valid Start
  always_ff @(posedge i_Clock or negedge i_ResetN) begin
    if (!i_ResetN) begin
      r_sweep_cnt <= 4'd0;
    end else if (w_accept && w_cfg_ok) begin
      r_sweep_cnt <= 4'd0;
    end else if (w_sweep_bump) begin
      r_sweep_cnt <= w_sweep_inc;
    end
  end

  // Error flag and saturating midpoint tally; both restart on a taken Start
  always_ff @(posedge i_Clock or negedge i_ResetN) begin
    if (!i_ResetN) begin
      r_error    <= 1'b0;
      r_mid_prev <= 1'b0;
      r_xings    <= 8'd0;
    end else if (w_accept) begin
      r_error    <= !w_cfg_ok;
      r_mid_prev <= 1'b0;
      if (w_cfg_ok) r_xings <= 8'd0;
    end else begin
      r_mid_prev <= bus.i_AtMidpoint;
      if (((r_state == S_UP) || (r_state == S_DOWN)) && w_rise && (r_xings != 8'hFF))
        r_xings <= r_xings + 8'd1;
    end
  end

  assign bus.o_InializeCount     = w_init;
  assign bus.o_EnableCount       = w_en;
  assign bus.o_CountUp           = w_up;
  assign bus.o_N                 = w_drive ? r_step : '0;
  assign bus.o_Busy              = w_active;
  assign bus.o_Done              = (r_state == S_DONE);
  assign bus.o_Error             = r_error;
  assign bus.o_MidpointCrossings = r_xings;

endmodule

// File: tb/tb_count_sweep_controller.sv
// Closed-loop bench: a behavioural 8-bit step counter is wired to the
// sequencer; on every accepted Start the whole expected control/count trace
// of the sweep is generated up front and compared cycle by cycle.
module tb_count_sweep_controller;
  localparam int COUNT_W   = 8;
  localparam int STEP_W    = 4;
  localparam int MID       = 127;
  localparam int TRACE_MAX = 4000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  count_sweep_controller_if #(.COUNT_W(COUNT_W), .STEP_W(STEP_W)) bus ();

  count_sweep_controller #(.COUNT_W(COUNT_W), .STEP_W(STEP_W), .MIDPOINT(MID)) dut (
    .i_Clock  (clk),
    .i_ResetN (rst_n),
    .bus      (bus)
  );

  // Behavioural counter: initialize wins, else step up/down modulo 256
  logic [7:0] cnt;
  logic       load_req;
  logic [7:0] load_val;
  always @(posedge clk) begin
    if (load_req)                  cnt <= load_val;
    else if (bus.o_InializeCount)  cnt <= 8'd127;
    else if (bus.o_EnableCount)    cnt <= bus.o_CountUp ? cnt + 8'(bus.o_N) : cnt - 8'(bus.o_N);
  end
  assign bus.i_Count      = cnt;
  assign bus.i_AtMidpoint = (cnt == 8'd127);

  int checks = 0;
  int errors = 0;
  int done_seen = 0;

  always @(negedge clk) if (rst_n && bus.o_Done === 1'b1) done_seen <= done_seen + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model: expected per-cycle trace ----------------
  typedef struct {
    bit       init;
    bit       en;
    bit       up;
    bit [3:0] n;
    bit       busy;
    bit       done;
    int       cnt;
    int       x;   // tally visible during the cycle
    int       xn;  // tally visible after the cycle's edge
  } ent_t;

  ent_t q[$];
  bit   exp_err = 1'b0;
  int   idle_x = 0;

  function automatic void emit(int c, int step, bit en, bit up, inout int x, inout bit prev);
    ent_t e;
    int   xn;
    xn = (c == MID && !prev && x < 255) ? x + 1 : x;
    e = '{init: 1'b0, en: en, up: up, n: 4'(step), busy: 1'b1, done: 1'b0,
          cnt: c, x: x, xn: xn};
    q.push_back(e);
    x = xn;
    prev = (c == MID);
  endfunction

  function automatic void build(int c0, int step, int lo, int hi, int sw);
    int   c;
    int   x;
    int   k;
    bit   prev;
    ent_t e;
    q.delete();
    x = 0;
    e = '{init: 1'b1, en: 1'b1, up: 1'b0, n: 4'(step), busy: 1'b1, done: 1'b0,
          cnt: c0, x: 0, xn: 0};
    q.push_back(e);
    prev = (c0 == MID);
    c = MID;
    k = 0;
    while (q.size() < TRACE_MAX) begin
      while (c + step <= hi && q.size() < TRACE_MAX) begin
        emit(c, step, 1'b1, 1'b1, x, prev);
        c = c + step;
      end
      emit(c, step, 1'b0, 1'b0, x, prev);
      while (c >= lo + step && q.size() < TRACE_MAX) begin
        emit(c, step, 1'b1, 1'b0, x, prev);
        c = c - step;
      end
      emit(c, step, 1'b0, 1'b0, x, prev);
      k = (k + 1) % 16;
      if (sw != 0 && k == sw) begin
        e = '{init: 1'b0, en: 1'b0, up: 1'b0, n: 4'd0, busy: 1'b0, done: 1'b1,
              cnt: c, x: x, xn: x};
        q.push_back(e);
        return;
      end
    end
  endfunction

  // ---------------- compare process ----------------
  initial begin
    ent_t e;
    bit   valid;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        chk("rst_init", bus.o_InializeCount, 0);
        chk("rst_en", bus.o_EnableCount, 0);
        chk("rst_n_out", bus.o_N, 0);
        chk("rst_busy", bus.o_Busy, 0);
        chk("rst_done", bus.o_Done, 0);
        chk("rst_err", bus.o_Error, 0);
        chk("rst_xings", bus.o_MidpointCrossings, 0);
        q.delete();
        exp_err = 1'b0;
        idle_x  = 0;
      end else if (q.size() > 0) begin
        e = q.pop_front();
        if (e.busy && bus.i_Stop) begin
          chk("stop_init", bus.o_InializeCount, 0);
          chk("stop_en", bus.o_EnableCount, 0);
          chk("stop_up", bus.o_CountUp, 0);
          chk("stop_n", bus.o_N, 0);
          chk("stop_busy", bus.o_Busy, 1);
          chk("stop_done", bus.o_Done, 0);
          q.delete();
        end else begin
          chk("init", bus.o_InializeCount, e.init);
          chk("en", bus.o_EnableCount, e.en);
          chk("up", bus.o_CountUp, e.up);
          chk("n", bus.o_N, e.n);
          chk("busy", bus.o_Busy, e.busy);
          chk("done", bus.o_Done, e.done);
        end
        chk("count", bus.i_Count, e.cnt);
        chk("xings", bus.o_MidpointCrossings, e.x);
        chk("error", bus.o_Error, exp_err);
        if (q.size() == 0) idle_x = e.xn;
      end else begin
        chk("idle_init", bus.o_InializeCount, 0);
        chk("idle_en", bus.o_EnableCount, 0);
        chk("idle_n", bus.o_N, 0);
        chk("idle_busy", bus.o_Busy, 0);
        chk("idle_done", bus.o_Done, 0);
        chk("idle_xings", bus.o_MidpointCrossings, idle_x);
        chk("idle_error", bus.o_Error, exp_err);
        if (bus.i_Start) begin
          valid = (bus.i_Step != 0) && (int'(bus.i_LowerLimit) <= MID) &&
                  (MID <= int'(bus.i_UpperLimit));
          exp_err = !valid;
          if (valid) begin
            idle_x = 0;
            build(int'(cnt), int'(bus.i_Step), int'(bus.i_LowerLimit),
                  int'(bus.i_UpperLimit), int'(bus.i_Sweeps));
          end
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_count(input int v);
    load_req = 1'b1;
    load_val = 8'(v);
    tick();
    load_req = 1'b0;
  endtask

  task automatic do_start(input int st, input int lo, input int hi, input int sw);
    bus.i_Step       = 4'(st);
    bus.i_LowerLimit = 8'(lo);
    bus.i_UpperLimit = 8'(hi);
    bus.i_Sweeps     = 4'(sw);
    bus.i_Start      = 1'b1;
    tick();
    bus.i_Start      = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while ((bus.o_Busy || bus.o_Done) && n < budget) begin
      tick();
      n++;
    end
    if (bus.o_Busy || bus.o_Done) begin
      chk("idle_timeout", bus.o_Busy, 0);
      bus.i_Stop = 1'b1;
      tick();
      bus.i_Stop = 1'b0;
    end
    tick();
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "bench timeout");
  end

  initial begin
    int d0;
    int st, lo, hi, sw, stop_at;
    bus.i_Start = 1'b0;
    bus.i_Stop = 1'b0;
    bus.i_Step = '0;
    bus.i_UpperLimit = '0;
    bus.i_LowerLimit = '0;
    bus.i_Sweeps = '0;
    load_req = 1'b1;
    load_val = 8'd0;
    rst_n = 1'b0;
    repeat (3) tick();
    chk("reset_busy", bus.o_Busy, 0);
    chk("reset_error", bus.o_Error, 0);
    chk("reset_xings", bus.o_MidpointCrossings, 0);
    chk("reset_en", bus.o_EnableCount, 0);
    load_req = 1'b0;
    rst_n = 1'b1;
    tick();

    // Rejected configurations
    do_start(0, 100, 150, 1);
    chk("err_step0", bus.o_Error, 1);
    chk("err_step0_busy", bus.o_Busy, 0);
    tick();
    do_start(10, 128, 150, 1);
    chk("err_lower128", bus.o_Error, 1);
    chk("err_lower128_busy", bus.o_Busy, 0);
    tick();

    // Basic single sweep 100..150 step 10
    set_count(0);
    d0 = done_seen;
    do_start(10, 100, 150, 1);
    chk("err_cleared", bus.o_Error, 0);
    wait_idle(100);
    chk("t1_xings", bus.o_MidpointCrossings, 2);
    chk("t1_count", cnt, 107);
    chk("t1_done_pulses", done_seen - d0, 1);

    // Step too large on both sides: turnarounds only
    set_count(50);
    d0 = done_seen;
    do_start(15, 120, 127, 3);
    wait_idle(100);
    chk("t3_count", cnt, 127);
    chk("t3_done_pulses", done_seen - d0, 1);

    // Full range, endless, stopped
    set_count(240);
    d0 = done_seen;
    do_start(15, 0, 255, 0);
    repeat (70) tick();
    bus.i_Stop = 1'b1;
    tick();
    bus.i_Stop = 1'b0;
    wait_idle(10);
    chk("fr_no_done", done_seen - d0, 0);

    // Stop in the second UP cycle
    set_count(0);
    d0 = done_seen;
    do_start(10, 100, 150, 1);
    tick();
    tick();
    bus.i_Stop = 1'b1;
    #1;
    chk("stop_same_cycle_en", bus.o_EnableCount, 0);
    tick();
    bus.i_Stop = 1'b0;
    chk("stop_next_busy", bus.o_Busy, 0);
    tick();
    chk("stop_count_hold", cnt, 137);
    chk("stop_no_done", done_seen - d0, 0);

    // Async reset mid-DOWN
    set_count(0);
    do_start(10, 100, 150, 0);
    repeat (5) tick();
    #1;
    rst_n = 1'b0;
    #1;
    chk("areset_en", bus.o_EnableCount, 0);
    chk("areset_busy", bus.o_Busy, 0);
    chk("areset_n", bus.o_N, 0);
    chk("areset_xings", bus.o_MidpointCrossings, 0);
    tick();
    rst_n = 1'b1;
    chk("areset_count_hold", cnt, 137);
    tick();
    chk("areset_idle", bus.o_Busy, 0);

    // Tally saturation
    set_count(0);
    do_start(10, 117, 137, 0);
    repeat (1000) tick();
    bus.i_Stop = 1'b1;
    tick();
    bus.i_Stop = 1'b0;
    wait_idle(10);
    chk("sat_xings", bus.o_MidpointCrossings, 255);

    // Randomized runs
    for (int r = 0; r < 20; r++) begin
      if ($urandom_range(0, 4) == 0) begin
        st = $urandom_range(0, 15);
        lo = $urandom_range(0, 255);
        hi = $urandom_range(0, 255);
      end else begin
        st = $urandom_range(2, 15);
        lo = $urandom_range(0, 127);
        hi = $urandom_range(127, 255);
      end
      sw = $urandom_range(0, 3);
      set_count($urandom_range(0, 255));
      do_start(st, lo, hi, sw);
      stop_at = (sw == 0 || $urandom_range(0, 2) == 0) ? $urandom_range(1, 80) : -1;
      for (int k = 0; k < 3000 && (bus.o_Busy || bus.o_Done); k++) begin
        if (k == stop_at) begin
          bus.i_Stop = 1'b1;
        end else if (bus.o_Busy && $urandom_range(0, 9) == 0) begin
          bus.i_Step       = 4'($urandom_range(0, 15));
          bus.i_LowerLimit = 8'($urandom_range(0, 255));
          bus.i_UpperLimit = 8'($urandom_range(0, 255));
          bus.i_Sweeps     = 4'($urandom_range(0, 15));
          bus.i_Start      = 1'b1;
        end
        tick();
        bus.i_Stop  = 1'b0;
        bus.i_Start = 1'b0;
      end
      wait_idle(10);
      if ($urandom_range(0, 1) == 1) begin
        bus.i_Stop = 1'b1;
        tick();
        bus.i_Stop = 1'b0;
      end
    end

    tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
